// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU arbitration controller (alu_arb_ctrl) and
// its round-robin arbiter (rr_arb2):
//   - ALU function codes (ADD..SHL_B, NOP = 4'b1000)
//   - result-class decode of a function code
//   - controller state encoding (IDLE / EXEC / RESP)
// No ports; imported with "import alu_ctrl_pkg::*;".
package alu_ctrl_pkg;

  // ALU function codes
  localparam logic [3:0] FUN_ADD   = 4'b0000;
  localparam logic [3:0] FUN_SUB   = 4'b0001;
  localparam logic [3:0] FUN_MUL   = 4'b0010;
  localparam logic [3:0] FUN_DIV   = 4'b0011;
  localparam logic [3:0] FUN_AND   = 4'b0100;
  localparam logic [3:0] FUN_OR    = 4'b0101;
  localparam logic [3:0] FUN_NAND  = 4'b0110;
  localparam logic [3:0] FUN_NOR   = 4'b0111;
  localparam logic [3:0] FUN_NOP   = 4'b1000;
  localparam logic [3:0] FUN_CMPEQ = 4'b1001;
  localparam logic [3:0] FUN_CMPGT = 4'b1010;
  localparam logic [3:0] FUN_CMPLT = 4'b1011;
  localparam logic [3:0] FUN_SHR_A = 4'b1100;
  localparam logic [3:0] FUN_SHL_A = 4'b1101;
  localparam logic [3:0] FUN_SHR_B = 4'b1110;
  localparam logic [3:0] FUN_SHL_B = 4'b1111;

  // Which ALU output group carries the result of a function
  typedef enum logic [2:0] {
    CLS_ARITH,
    CLS_LOGIC,
    CLS_CMP,
    CLS_SHIFT,
    CLS_NOP
  } fun_cls_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The two MSBs pick the group; in the 10xx group only 1000 is NOP.
  function automatic fun_cls_e fun_class(input logic [3:0] fun);
    fun_cls_e cls;
    case (fun[3:2])
      2'b00:   cls = CLS_ARITH;
      2'b01:   cls = CLS_LOGIC;
      2'b10:   cls = (fun[1:0] == 2'b00) ? CLS_NOP : CLS_CMP;
      default: cls = CLS_SHIFT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Grants are combinational and only issued
// while en is high; the "last granted" pointer is updated whenever a grant
// is issued (a grant always coincides with an accepted request).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         arbitration allowed this cycle
//   req[1:0]   request lines
//   gnt[1:0]   one-hot grant (or zero)
module rr_arb2
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index granted most recently. Resets to 1 so requester 0 wins the
  // first tie.
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
      else                  gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl
// Shares one registered-output ALU between two requesters. A round-robin
// grant in IDLE latches the command onto the ALU operand/function outputs,
// EXEC waits ALU_LAT+1 cycles, the result of the function's class is
// captured on the last EXEC edge and presented on the response channel
// (RESP) until the consumer accepts it.
// Parameters: WIDTH (operand width), ALU_LAT (ALU latency, 1..4).
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   REQn_VALID/READY/FUN/A/B     requester n command channel (n = 0,1)
//   ALU_A, ALU_B, ALU_FUN        registered ALU inputs (FUN = NOP when idle)
//   ALU_*_OUT, ALU_*_FLAG        ALU result groups
//   RSP_VALID/READY/ID/DATA/FLAG response channel
// Optional build macro ALU_ARB_PERF_EN adds GRANT_CNT0/GRANT_CNT1, 16-bit
// saturating per-requester grant counters.
module alu_arb_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0_VALID,
  output logic               REQ0_READY,
  input  logic [3:0]         REQ0_FUN,
  input  logic [WIDTH-1:0]   REQ0_A,
  input  logic [WIDTH-1:0]   REQ0_B,
  input  logic               REQ1_VALID,
  output logic               REQ1_READY,
  input  logic [3:0]         REQ1_FUN,
  input  logic [WIDTH-1:0]   REQ1_A,
  input  logic [WIDTH-1:0]   REQ1_B,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  output logic [3:0]         ALU_FUN,
  input  logic [2*WIDTH-1:0] ALU_ARITH_OUT,
  input  logic               ALU_ARITH_FLAG,
  input  logic [WIDTH-1:0]   ALU_LOGIC_OUT,
  input  logic               ALU_LOGIC_FLAG,
  input  logic [2:0]         ALU_CMP_OUT,
  input  logic               ALU_CMP_FLAG,
  input  logic [WIDTH-1:0]   ALU_SHIFT_OUT,
  input  logic               ALU_SHIFT_FLAG,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [2*WIDTH-1:0] RSP_DATA,
  output logic               RSP_FLAG
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]        GRANT_CNT0,
  output logic [15:0]        GRANT_CNT1
`endif
);

  localparam int CNT_W = 3;

  typedef struct packed {
    logic [3:0]       fun;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  state_e             state, state_nx;
  logic [1:0]         gnt;
  logic [CNT_W-1:0]   cnt;
  logic               cur_id;
  cmd_t               cmd0, cmd1, cmd_sel;
  logic [2*WIDTH-1:0] sel_data;
  logic               sel_flag;
  logic               exec_last;

  // ---------------------------------------------------------------- arbiter
  rr_arb2 u_arb (
    .clk (CLK),
    .rst (RST),
    .en  (state == IDLE),
    .req ({REQ1_VALID, REQ0_VALID}),
    .gnt (gnt)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];

  assign cmd0    = '{fun: REQ0_FUN, a: REQ0_A, b: REQ0_B};
  assign cmd1    = '{fun: REQ1_FUN, a: REQ1_A, b: REQ1_B};
  assign cmd_sel = gnt[1] ? cmd1 : cmd0;

  // Down-counter reaches zero on the final EXEC cycle.
  assign exec_last = (state == EXEC) && (cnt == '0);

  // ---------------------------------------------------------- result select
  // ALU_FUN still holds the command during the final EXEC cycle, so it
  // drives the class decode directly.
  always_comb begin
    sel_data = '0;
    sel_flag = 1'b0;
    case (fun_class(ALU_FUN))
      CLS_ARITH: begin
        sel_data = ALU_ARITH_OUT;
        sel_flag = ALU_ARITH_FLAG;
      end
      CLS_LOGIC: begin
        sel_data = {{WIDTH{1'b0}}, ALU_LOGIC_OUT};
        sel_flag = ALU_LOGIC_FLAG;
      end
      CLS_CMP: begin
        sel_data = {{(2*WIDTH-3){1'b0}}, ALU_CMP_OUT};
        sel_flag = ALU_CMP_FLAG;
      end
      CLS_SHIFT: begin
        sel_data = {{WIDTH{1'b0}}, ALU_SHIFT_OUT};
        sel_flag = ALU_SHIFT_FLAG;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|gnt)     state_nx = EXEC;
      EXEC:    if (exec_last) state_nx = RESP;
      RESP:    if (RSP_READY) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= FUN_NOP;
      cnt      <= '0;
      cur_id   <= 1'b0;
      RSP_ID   <= 1'b0;
      RSP_DATA <= '0;
      RSP_FLAG <= 1'b0;
    end else begin
      if ((state == IDLE) && (|gnt)) begin
        ALU_A   <= cmd_sel.a;
        ALU_B   <= cmd_sel.b;
        ALU_FUN <= cmd_sel.fun;
        cur_id  <= gnt[1];
        cnt     <= CNT_W'(ALU_LAT);
      end else if (state == EXEC) begin
        if (exec_last) begin
          ALU_FUN  <= FUN_NOP;
          RSP_ID   <= cur_id;
          RSP_DATA <= sel_data;
          RSP_FLAG <= sel_flag;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign RSP_VALID = (state == RESP);

`ifdef ALU_ARB_PERF_EN
  // ----------------------------------------------------- grant statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      GRANT_CNT0 <= '0;
      GRANT_CNT1 <= '0;
    end else begin
      if (gnt[0] && (GRANT_CNT0 != 16'hFFFF)) GRANT_CNT0 <= GRANT_CNT0 + 16'd1;
      if (gnt[1] && (GRANT_CNT1 != 16'hFFFF)) GRANT_CNT1 <= GRANT_CNT1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb_alu_arb_ctrl
// Bench for alu_arb_ctrl: behavioural ALU with registered outputs (unused
// result groups carry random data), a per-cycle reference monitor for the
// arbitration / timing / response rules, a directed vector table, hand
// sequences for tie, backpressure and mid-EXEC reset, then random traffic.
module tb_alu_arb_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [3:0]    REQ0_FUN, REQ1_FUN;
  logic [W-1:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [W-1:0]  ALU_A, ALU_B;
  logic [3:0]    ALU_FUN;
  logic [2*W-1:0] ALU_ARITH_OUT;
  logic          ALU_ARITH_FLAG;
  logic [W-1:0]  ALU_LOGIC_OUT;
  logic          ALU_LOGIC_FLAG;
  logic [2:0]    ALU_CMP_OUT;
  logic          ALU_CMP_FLAG;
  logic [W-1:0]  ALU_SHIFT_OUT;
  logic          ALU_SHIFT_FLAG;
  logic          RSP_VALID, RSP_READY, RSP_ID, RSP_FLAG;
  logic [2*W-1:0] RSP_DATA;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]   GRANT_CNT0, GRANT_CNT1;
`endif

  always #5 CLK = ~CLK;

  alu_arb_ctrl #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_FUN(REQ0_FUN),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_FUN(REQ1_FUN),
    .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_ARITH_OUT(ALU_ARITH_OUT), .ALU_ARITH_FLAG(ALU_ARITH_FLAG),
    .ALU_LOGIC_OUT(ALU_LOGIC_OUT), .ALU_LOGIC_FLAG(ALU_LOGIC_FLAG),
    .ALU_CMP_OUT(ALU_CMP_OUT), .ALU_CMP_FLAG(ALU_CMP_FLAG),
    .ALU_SHIFT_OUT(ALU_SHIFT_OUT), .ALU_SHIFT_FLAG(ALU_SHIFT_FLAG),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_FLAG(RSP_FLAG)
`ifdef ALU_ARB_PERF_EN
    , .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1)
`endif
  );

  // ------------------------------------------------ ALU result definitions
  function automatic logic [32:0] f_arith(input logic [3:0] fun, input logic [15:0] a, b);
    logic signed [15:0] sa, sb;
    logic signed [31:0] xa, xb, r;
    sa = a; sb = b; xa = sa; xb = sb;
    case (fun[1:0])
      2'd0:    r = xa + xb;
      2'd1:    r = xa - xb;
      2'd2:    r = xa * xb;
      default: r = (xb == 0) ? 32'sd0 : xa / xb;
    endcase
    return {r[31], r};
  endfunction

  function automatic logic [16:0] f_logic(input logic [3:0] fun, input logic [15:0] a, b);
    logic [15:0] r;
    case (fun[1:0])
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = ~(a & b);
      default: r = ~(a | b);
    endcase
    return {(r == 16'd0), r};
  endfunction

  function automatic logic [3:0] f_cmp(input logic [3:0] fun, input logic [15:0] a, b);
    logic signed [15:0] sa, sb;
    logic [2:0] r;
    sa = a; sb = b;
    case (fun)
      FUN_CMPEQ: r = (sa == sb) ? 3'b001 : 3'b000;
      FUN_CMPGT: r = (sa >  sb) ? 3'b010 : 3'b000;
      FUN_CMPLT: r = (sa <  sb) ? 3'b100 : 3'b000;
      default:   r = 3'b000;
    endcase
    return {(r != 3'b000), r};
  endfunction

  function automatic logic [16:0] f_shift(input logic [3:0] fun, input logic [15:0] a, b);
    logic [15:0] r;
    case (fun[1:0])
      2'd0:    r = a >> 1;
      2'd1:    r = a << 1;
      2'd2:    r = b >> 1;
      default: r = b << 1;
    endcase
    return {(r == 16'd0), r};
  endfunction

  // Expected response {flag, data} for a command.
  function automatic logic [32:0] expect_rsp(input logic [3:0] fun, input logic [15:0] a, b);
    logic [16:0] t;
    logic [3:0]  c;
    if (fun <= 4'd3) return f_arith(fun, a, b);
    if (fun <= 4'd7) begin t = f_logic(fun, a, b); return {t[16], 16'd0, t[15:0]}; end
    if (fun == 4'd8) return 33'd0;
    if (fun <= 4'd11) begin c = f_cmp(fun, a, b); return {c[3], 29'd0, c[2:0]}; end
    t = f_shift(fun, a, b);
    return {t[16], 16'd0, t[15:0]};
  endfunction

  // ------------------------------------------- behavioural registered ALU
  typedef struct packed {
    logic [31:0] ar; logic af;
    logic [15:0] lo; logic lf;
    logic [2:0]  cm; logic cf;
    logic [15:0] sh; logic sf;
  } alu_o_t;

  function automatic alu_o_t alu_eval(input logic [3:0] fun, input logic [15:0] a, b);
    alu_o_t o;
    logic [32:0] t33;
    logic [16:0] t17;
    logic [3:0]  t4;
    o.ar = $urandom; o.af = 1'($urandom); o.lo = 16'($urandom); o.lf = 1'($urandom);
    o.cm = 3'($urandom); o.cf = 1'($urandom); o.sh = 16'($urandom); o.sf = 1'($urandom);
    if (fun <= 4'd3) begin t33 = f_arith(fun, a, b); {o.af, o.ar} = t33; end
    else if (fun <= 4'd7) begin t17 = f_logic(fun, a, b); {o.lf, o.lo} = t17; end
    else if (fun >= 4'd9 && fun <= 4'd11) begin t4 = f_cmp(fun, a, b); {o.cf, o.cm} = t4; end
    else if (fun >= 4'd12) begin t17 = f_shift(fun, a, b); {o.sf, o.sh} = t17; end
    return o;
  endfunction

  alu_o_t alu_pipe [LAT];
  always @(posedge CLK) begin
    alu_pipe[0] <= alu_eval(ALU_FUN, ALU_A, ALU_B);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign ALU_ARITH_OUT  = alu_pipe[LAT-1].ar;
  assign ALU_ARITH_FLAG = alu_pipe[LAT-1].af;
  assign ALU_LOGIC_OUT  = alu_pipe[LAT-1].lo;
  assign ALU_LOGIC_FLAG = alu_pipe[LAT-1].lf;
  assign ALU_CMP_OUT    = alu_pipe[LAT-1].cm;
  assign ALU_CMP_FLAG   = alu_pipe[LAT-1].cf;
  assign ALU_SHIFT_OUT  = alu_pipe[LAT-1].sh;
  assign ALU_SHIFT_FLAG = alu_pipe[LAT-1].sf;

  // ------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle reference: one operation in flight, handshake cycle T puts the
  // command on the ALU for T+1..T+LAT+1 and the response valid from T+LAT+2.
  logic        chk_en = 1'b0;
  int          cyc = 0;
  logic        busy, last_gnt, e0, e1, in_exec, in_resp;
  int          hs_cyc;
  logic [3:0]  x_fun;
  logic [15:0] x_a, x_b;
  logic        x_id;
  logic [32:0] x_rsp;

  initial begin
    busy = 1'b0; last_gnt = 1'b1; hs_cyc = 0;
    x_fun = FUN_NOP; x_a = '0; x_b = '0; x_id = 1'b0; x_rsp = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        busy = 1'b0;
        last_gnt = 1'b1;
      end else if (chk_en) begin
        e0 = 1'b0; e1 = 1'b0;
        if (!busy) begin
          if (REQ0_VALID && REQ1_VALID) begin e0 = last_gnt; e1 = !last_gnt; end
          else begin e0 = REQ0_VALID; e1 = REQ1_VALID; end
        end
        check("req0_ready", 32'(REQ0_READY), 32'(e0));
        check("req1_ready", 32'(REQ1_READY), 32'(e1));
        in_exec = busy && (cyc > hs_cyc) && (cyc <= hs_cyc + LAT + 1);
        in_resp = busy && (cyc >= hs_cyc + LAT + 2);
        check("alu_fun", 32'(ALU_FUN), 32'(in_exec ? x_fun : FUN_NOP));
        if (in_exec) begin
          check("alu_a", 32'(ALU_A), 32'(x_a));
          check("alu_b", 32'(ALU_B), 32'(x_b));
        end
        check("rsp_valid", 32'(RSP_VALID), 32'(in_resp));
        if (in_resp) begin
          check("rsp_id", 32'(RSP_ID), 32'(x_id));
          check("rsp_data", RSP_DATA, x_rsp[31:0]);
          check("rsp_flag", 32'(RSP_FLAG), 32'(x_rsp[32]));
        end
        if (in_resp && RSP_READY) busy = 1'b0;
        else if (e0 || e1) begin
          busy = 1'b1; hs_cyc = cyc; x_id = e1; last_gnt = e1;
          x_fun = e1 ? REQ1_FUN : REQ0_FUN;
          x_a   = e1 ? REQ1_A   : REQ0_A;
          x_b   = e1 ? REQ1_B   : REQ0_B;
          x_rsp = expect_rsp(x_fun, x_a, x_b);
        end
      end
    end
  end

  // --------------------------------------------------------------- driving
  logic h0, h1;
  logic        rsp_ids [$];
  logic [31:0] rsp_dat [$];
  logic        rsp_flg [$];

  task automatic set_req(input logic id, input logic [3:0] fun, input logic [15:0] a, b);
    if (!id) begin REQ0_FUN = fun; REQ0_A = a; REQ0_B = b; REQ0_VALID = 1'b1; end
    else     begin REQ1_FUN = fun; REQ1_A = a; REQ1_B = b; REQ1_VALID = 1'b1; end
  endtask

  // One clock: sample at negedge, then drop VALID of any accepted request.
  task automatic step();
    @(negedge CLK);
    h0 = REQ0_VALID && REQ0_READY;
    h1 = REQ1_VALID && REQ1_READY;
    if (RSP_VALID && RSP_READY) begin
      rsp_ids.push_back(RSP_ID);
      rsp_dat.push_back(RSP_DATA);
      rsp_flg.push_back(RSP_FLAG);
    end
    @(posedge CLK); #1;
    if (h0) REQ0_VALID = 1'b0;
    if (h1) REQ1_VALID = 1'b0;
  endtask

  task automatic drain();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b1;
    repeat (LAT + 6) step();
  endtask

  function automatic logic [15:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [3:0]  fun;
    logic [15:0] a, b;
    logic [31:0] data;
    logic        flag;
  } vec_t;
  vec_t vecs [9];

  logic [31:0] tie_id [3] = '{32'd0, 32'd1, 32'd0};
  logic [31:0] tie_d  [3] = '{32'd5, 32'hFFFF_FFFF, 32'h0000_000F};
  logic [31:0] tie_f  [3] = '{32'd0, 32'd1, 32'd0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, FUN_MUL,   16'hFFFE, 16'hFFFD, 32'd6,        1'b0};
    vecs[1] = '{1'b1, FUN_CMPGT, 16'd3,    16'd2,    32'd2,        1'b1};
    vecs[2] = '{1'b1, FUN_NOP,   16'd7,    16'd9,    32'd0,        1'b0};
    vecs[3] = '{1'b0, FUN_AND,   16'h00F0, 16'h0F00, 32'd0,        1'b1};
    vecs[4] = '{1'b1, FUN_OR,    16'h00F0, 16'h0F00, 32'h0FF0,     1'b0};
    vecs[5] = '{1'b0, FUN_SHL_A, 16'h8000, 16'h0000, 32'd0,        1'b1};
    vecs[6] = '{1'b0, FUN_CMPLT, 16'hFFFF, 16'h0001, 32'd4,        1'b1};
    vecs[7] = '{1'b1, FUN_DIV,   16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b1};
    vecs[8] = '{1'b0, FUN_SHR_B, 16'h1234, 16'hFFFF, 32'h7FFF,     1'b0};

    RST = 1'b1; RSP_READY = 1'b0; h0 = 1'b0; h1 = 1'b0;
    REQ0_VALID = 1'b0; REQ0_FUN = '0; REQ0_A = '0; REQ0_B = '0;
    REQ1_VALID = 1'b0; REQ1_FUN = '0; REQ1_A = '0; REQ1_B = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_alu_a",    32'(ALU_A),     32'd0);
    check("rst_alu_b",    32'(ALU_B),     32'd0);
    check("rst_alu_fun",  32'(ALU_FUN),   32'(FUN_NOP));
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_id",   32'(RSP_ID),    32'd0);
    check("rst_rsp_data", RSP_DATA,       32'd0);
    check("rst_rsp_flag", 32'(RSP_FLAG),  32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; chk_en = 1'b1;

    // Tie after reset; REQ0 re-raised while REQ1 still waits
    RSP_READY = 1'b1;
    set_req(1'b0, FUN_ADD, 16'd2, 16'd3);
    set_req(1'b1, FUN_SUB, 16'd2, 16'd3);
    n = 0;
    for (int k = 0; k < 60 && rsp_ids.size() < 3; k++) begin
      step();
      if (h0 && n == 0) begin set_req(1'b0, FUN_AND, 16'h00FF, 16'h0F0F); n = 1; end
    end
    check("tie_rsp_count", 32'(rsp_ids.size()), 32'd3);
    for (int i = 0; i < 3 && i < rsp_ids.size(); i++) begin
      check("tie_id",   32'(rsp_ids[i]), tie_id[i]);
      check("tie_data", rsp_dat[i],      tie_d[i]);
      check("tie_flag", 32'(rsp_flg[i]), tie_f[i]);
    end
    drain();

    // Directed vector table, one request at a time
    for (int i = 0; i < 9; i++) begin
      n = rsp_ids.size();
      set_req(vecs[i].id, vecs[i].fun, vecs[i].a, vecs[i].b);
      for (int k = 0; k < 40 && rsp_ids.size() == n; k++) step();
      check("vec_done", 32'(rsp_ids.size() > n), 32'd1);
      if (rsp_ids.size() > n) begin
        check("vec_id",   32'(rsp_ids[n]), 32'(vecs[i].id));
        check("vec_data", rsp_dat[n],      vecs[i].data);
        check("vec_flag", 32'(rsp_flg[n]), 32'(vecs[i].flag));
      end
    end
    drain();

    // Backpressure: response held 5+ cycles, REQ0 waits, grant one cycle
    // after the response handshake
    RSP_READY = 1'b0;
    n = rsp_ids.size();
    set_req(1'b0, FUN_ADD, 16'd1, 16'd1);
    h0 = 1'b0;
    for (int k = 0; k < 20 && !h0; k++) step();
    check("bp_first_grant", 32'(h0), 32'd1);
    set_req(1'b0, FUN_OR, 16'd1, 16'd2);
    for (int k = 0; k < LAT + 6; k++) begin
      step();
      check("bp_no_grant", 32'(h0), 32'd0);
    end
    RSP_READY = 1'b1;
    step();
    check("bp_rsp_hs", 32'(rsp_ids.size()), 32'(n + 1));
    check("bp_no_same_cycle_grant", 32'(h0), 32'd0);
    step();
    check("bp_grant_next", 32'(h0), 32'd1);
    for (int k = 0; k < 20 && rsp_ids.size() < n + 2; k++) step();
    check("bp_rsp_count", 32'(rsp_ids.size()), 32'(n + 2));
    if (rsp_ids.size() >= n + 2) begin
      check("bp_data0", rsp_dat[n],     32'd2);
      check("bp_data1", rsp_dat[n + 1], 32'd3);
    end
    drain();

    // Reset in the middle of EXEC
    set_req(1'b0, FUN_MUL, 16'd5, 16'd5);
    h0 = 1'b0;
    for (int k = 0; k < 20 && !h0; k++) step();
    check("rst_exec_grant", 32'(h0), 32'd1);
    n = rsp_ids.size();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_exec_fun_nop", 32'(ALU_FUN),   32'(FUN_NOP));
    check("rst_exec_no_valid", 32'(RSP_VALID), 32'd0);
    @(posedge CLK); #1;
    repeat (LAT + 6) step();
    check("rst_exec_no_rsp", 32'(rsp_ids.size()), 32'(n));
    set_req(1'b0, FUN_ADD, 16'd1, 16'd2);
    set_req(1'b1, FUN_SUB, 16'd1, 16'd2);
    h0 = 1'b0; h1 = 1'b0;
    for (int k = 0; k < 20 && !(h0 || h1); k++) step();
    check("rst_tie_req0", 32'(h0), 32'd1);
    check("rst_tie_req1", 32'(h1), 32'd0);
    for (int k = 0; k < 20; k++) step();
    drain();

    // Random traffic, checked by the monitor
    for (int c = 0; c < 3000; c++) begin
      RSP_READY = ($urandom_range(0, 3) != 0);
      if (!REQ0_VALID) begin
        if ($urandom_range(0, 2) == 0)
          set_req(1'b0, 4'($urandom), rnd_opnd(), rnd_opnd());
      end else if ($urandom_range(0, 15) == 0) REQ0_VALID = 1'b0;
      if (!REQ1_VALID) begin
        if ($urandom_range(0, 2) == 0)
          set_req(1'b1, 4'($urandom), rnd_opnd(), rnd_opnd());
      end else if ($urandom_range(0, 15) == 0) REQ1_VALID = 1'b0;
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
